// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the I-cache read port and the
// decoder array. It accepts one FETCH_W-wide group per cycle and presents up
// to FETCH_W of the oldest instructions to decode. Decode may consume any
// number of them. Flush and front-end freeze are also handled here.
// Optional build macro FQ_BYPASS_EN: when the queue is empty, an incoming
// group goes straight to the decode window in the same cycle.
module fetch_queue #(
  parameter int FETCH_W = 3,
  parameter int INST_W  = 13,
  parameter int PC_W    = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int DQ_W    = $clog2(FETCH_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_in,
  input  logic                      freeze_front_in,
  input  logic                      valid_fetch_in,
  input  logic [PC_W-1:0]           pc_in,
  input  logic [FETCH_W*INST_W-1:0] ic_data_in,
  output logic                      ready_fetch_out,
  input  logic [DQ_W-1:0]           deq_cnt_in,
  output logic [FETCH_W*INST_W-1:0] inst_out,
  output logic [FETCH_W*PC_W-1:0]   pc_out,
  output logic [FETCH_W-1:0]        valid_out,
  output logic [CNT_W-1:0]          count_out,
  output logic                      empty_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FW_C      = CNT_W'(FETCH_W);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_W);

  // NOTE: storage is not reset; head/tail/count define what is valid, so the
  // contents of the arrays after reset do not matter.
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq;
  logic             bypass;
  logic [CNT_W-1:0] deq_req;
  logic [CNT_W-1:0] deq_eff;

  // Enqueue/dequeue decisions and next-state pointers and count.
  // NOTE: every signal written in always_comb gets a default value first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    ready_fetch_out = (count_q <= READY_MAX);
    // Reset also blocks enq, so the bypass window cannot show data during reset.
    enq = valid_fetch_in & ready_fetch_out & ~freeze_front_in & ~flush_in & ~rst;

    deq_req = CNT_W'(deq_cnt_in);
    if (deq_req > FW_C) deq_req = FW_C;

    bypass = 1'b0;
`ifdef FQ_BYPASS_EN
    bypass = enq && (count_q == '0);
`endif

    // A bypassed group is dequeued directly from the fetch bus. Otherwise
    // dequeue is limited to what is already stored.
    if (bypass)                  deq_eff = deq_req;
    else if (deq_req > count_q)  deq_eff = count_q;
    else                         deq_eff = deq_req;
    if (freeze_front_in || flush_in) deq_eff = '0;

    head_d  = head_q + PTR_W'(deq_eff);
    tail_d  = enq ? tail_q + PTR_W'(FETCH_W) : tail_q;
    count_d = count_q + (enq ? FW_C : '0) - deq_eff;
  end

  // Pointer and occupancy registers; reset and flush both empty the queue.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that were present before the clock edge.
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (!freeze_front_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the fetch group at tail. Slots already taken by a bypass are skipped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (enq && (!bypass || (CNT_W'(i) >= deq_eff))) begin
        inst_mem[tail_q + PTR_W'(i)] <= ic_data_in[i*INST_W +: INST_W];
        pc_mem[tail_q + PTR_W'(i)]   <= pc_in + PC_W'(i);
      end
    end
  end

  // Decode window: the oldest FETCH_W entries; unused slots are driven to zero.
  always_comb begin
    inst_out  = '0;
    pc_out    = '0;
    valid_out = '0;
    for (int i = 0; i < FETCH_W; i++) begin
`ifdef FQ_BYPASS_EN
      if (bypass) begin
        valid_out[i]                = 1'b1;
        inst_out[i*INST_W +: INST_W] = ic_data_in[i*INST_W +: INST_W];
        pc_out[i*PC_W +: PC_W]       = pc_in + PC_W'(i);
      end else
`endif
      if (CNT_W'(i) < count_q) begin
        valid_out[i]                 = 1'b1;
        inst_out[i*INST_W +: INST_W] = inst_mem[head_q + PTR_W'(i)];
        pc_out[i*PC_W +: PC_W]       = pc_mem[head_q + PTR_W'(i)];
      end
    end
  end

  assign count_out = count_q;
  assign empty_out = (count_q == '0);

endmodule
